// File: rtl/vecmac_pkg.sv
// Shared constants and state type for the vecmac sequencer slice.
//   LANES       byte lanes per operand word
//   MUL_OUT_W   width of the multiplier lane-sum output
//   MUL_LAT_DEF default multiplier latency in cycles
package vecmac_pkg;

    localparam int LANES       = 4;
    localparam int MUL_OUT_W   = 18;
    localparam int MUL_LAT_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/vecmac_acc.sv
// Dot-product accumulator with clear, add and optional saturation.
// Optional feature macro: VECMAC_SEQ_SAT_EN
//   defined   : acc saturates at all-ones, ovf_o is sticky until clr_i
//   undefined : acc wraps modulo 2^ACC_W, ovf_o is constant 0
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   clr_i  in   clear acc and ovf (command accept)
//   add_i  in   add din_i into acc
//   din_i  in   unsigned addend, IN_W bits, zero-extended
//   acc_o  out  accumulator value
//   ovf_o  out  sticky overflow flag
module vecmac_acc #(
    parameter int ACC_W = 32,
    parameter int IN_W  = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [IN_W-1:0]  din_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

`ifdef VECMAC_SEQ_SAT_EN
    logic [ACC_W:0] sum;

    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_W+1)'(din_i);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_i) begin
            // Carry out of the top bit means the true sum no longer fits.
            if (sum[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        acc_d = acc_q;
        ovf_d = 1'b0;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + ACC_W'(din_i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/vecmac_seq.sv
// Sequencer feeding the 4-lane int8 multiply/add-tree unit: accepts a
// command of N operand words, issues them to the multiplier through a
// register stage, accumulates the returned lane sums and presents one
// dot-product result per command.
// Optional feature macro: VECMAC_SEQ_SAT_EN (saturating acc + res_ovf,
// handled entirely inside vecmac_acc).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/len       command handshake, len = word count N
//   s_valid/ready/a/b         operand word stream (4 x uint8 per word)
//   mul_in_valid/a/b          registered issue to the multiplier
//   mul_out_valid/sum         multiplier return (no stall)
//   res_valid/ready/sum/ovf   result handshake
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | accepting operand words and issuing them
// DRAIN | all words issued, collecting remaining returns
// DONE  | result presented until res_ready
module vecmac_seq
    import vecmac_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int ACC_W   = 32,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_a,
    input  logic [31:0]          s_b,
    output logic                 mul_in_valid,
    output logic [31:0]          mul_in_a,
    output logic [31:0]          mul_in_b,
    input  logic                 mul_out_valid,
    input  logic [MUL_OUT_W-1:0] mul_out_sum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     res_sum,
    output logic                 res_ovf
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0] ret_cnt_q, ret_cnt_d;
    logic [LEN_W-1:0] issue_inc, ret_inc;
    logic             mul_in_valid_q;
    logic [31:0]      mul_in_a_q, mul_in_b_q;
    logic             cmd_hs, beat, ret, acc_ovf;

    assign cmd_ready = (state_q == IDLE);
    assign s_ready   = (state_q == ISSUE);
    assign res_valid = (state_q == DONE);

    assign cmd_hs = cmd_valid & cmd_ready;
    assign beat   = s_valid & s_ready;
    // Returns outside ISSUE/DRAIN belong to no live command.
    assign ret    = mul_out_valid & ((state_q == ISSUE) | (state_q == DRAIN));

    assign issue_inc = issue_cnt_q + LEN_W'(1);
    assign ret_inc   = ret_cnt_q + LEN_W'(ret);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_inc;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    len_d       = cmd_len;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    state_d     = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (beat) begin
                    issue_cnt_d = issue_inc;
                    if (issue_inc == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Look at the post-increment count so DONE lands right
                // after the edge that absorbs the last return.
                if (ret_inc == len_q) state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            mul_in_valid_q <= 1'b0;
            mul_in_a_q     <= '0;
            mul_in_b_q     <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            issue_cnt_q    <= issue_cnt_d;
            ret_cnt_q      <= ret_cnt_d;
            mul_in_valid_q <= beat;
            if (beat) begin
                mul_in_a_q <= s_a;
                mul_in_b_q <= s_b;
            end
        end
    end

    assign mul_in_valid = mul_in_valid_q;
    assign mul_in_a     = mul_in_a_q;
    assign mul_in_b     = mul_in_b_q;

    vecmac_acc #(
        .ACC_W (ACC_W),
        .IN_W  (MUL_OUT_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cmd_hs),
        .add_i (ret),
        .din_i (mul_out_sum),
        .acc_o (res_sum),
        .ovf_o (acc_ovf)
    );

    assign res_ovf = res_valid & acc_ovf;

    // The multiplier cannot stall, so issued-but-unreturned words are
    // bounded by its pipeline depth plus the issue register.
    in_flight_bound: assert property (@(posedge clk) disable iff (rst)
        (issue_cnt_q - ret_cnt_q) <= LEN_W'(MUL_LAT + 1));

endmodule
